gr_cpu_cycle_seq: RTL and testbench

GR_CPU_CYCLE_SEQ -- requirements
Module: gr_cpu_cycle_seq

---
 rtl/gr_cpu_cycle_seq.sv | 206 ++++++++++++++++++++
 tb/tb_gr_cpu_cycle_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gr_cpu_cycle_seq.sv
// CPU-side memory cycle sequencer: splits one host access into per-byte memory
// cycles, mapping each lane to an address/plane according to the graphics mode.
module gr_cpu_cycle_seq #(
  parameter int HBYTES = 4,
  parameter int AW     = 23
) (
  input  logic                  t_mem_clk,
  input  logic                  h_reset,
  input  logic                  h_req,
  input  logic                  h_wr,
  input  logic [AW-1:0]         h_addr,
  input  logic [HBYTES-1:0]     h_byte_en,
  input  logic [8*HBYTES-1:0]   h_wdata,
  input  logic [1:0]            g_mode,
  input  logic                  m_full,
  input  logic                  m_rvalid,
  input  logic [7:0]            m_rdata,
  output logic                  m_req,
  output logic                  m_wr,
  output logic [AW-1:0]         m_addr,
  output logic [3:0]            m_plane,
  output logic [7:0]            m_wdata,
  output logic                  h_done,
  output logic [8*HBYTES-1:0]   h_rdata,
  output logic                  g_busy
);

  localparam int LW = $clog2(HBYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAITRD = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  wr_r;
  logic [AW-1:0]         addr_r;
  logic [8*HBYTES-1:0]   wdata_r;
  logic [1:0]            mode_r;
  logic [HBYTES-1:0]     pend_r;
  logic [LW-1:0]         lane_r;
  logic                  m_wr_r;
  logic [AW-1:0]         m_addr_r;
  logic [3:0]            m_plane_r;
  logic [7:0]            m_wdata_r;
  logic                  h_done_r;
  logic [8*HBYTES-1:0]   h_rdata_r;
  logic                  g_busy_r;

  logic                  issue_s;
  logic [LW-1:0]         cur_lane_s;
  logic [LW-1:0]         next_lane_s;
  logic [LW-1:0]         first_lane_s;
  logic [HBYTES-1:0]     lane_bit_s;
  logic [HBYTES-1:0]     pend_clr_s;

  function automatic logic [LW-1:0] lowest_lane(input logic [HBYTES-1:0] mask);
    logic [LW-1:0] idx;
    idx = {LW{1'b0}};
    for (int i = HBYTES - 1; i >= 0; i--) begin
      if (mask[i]) idx = LW'(i);
      else         idx = idx;
    end
    return idx;
  endfunction

  // Address for a lane; the lane offset wraps modulo 2^AW.
  function automatic logic [AW-1:0] lane_addr(input logic [AW-1:0] base,
                                               input logic [LW-1:0] lane,
                                               input logic [1:0]    mode);
    logic [AW-1:0] a;
    a = base + AW'(lane);
    case (mode)
      2'b01:   lane_addr = {a[AW-1:1], 1'b0};
      2'b10:   lane_addr = {a[AW-1:2], 2'b00};
      default: lane_addr = a;
    endcase
  endfunction

  function automatic logic [3:0] lane_plane(input logic [AW-1:0] base,
                                            input logic [LW-1:0] lane,
                                            input logic [1:0]    mode);
    logic [AW-1:0] a;
    a = base + AW'(lane);
    case (mode)
      2'b01:   lane_plane = a[0] ? 4'b1010 : 4'b0101;
      2'b10:   lane_plane = 4'b0001 << a[1:0];
      default: lane_plane = 4'b1111;
    endcase
  endfunction

  function automatic logic [7:0] lane_byte(input logic [8*HBYTES-1:0] data,
                                           input logic [LW-1:0]       lane);
    return data[{lane, 3'b000} +: 8];
  endfunction

  // Lane bookkeeping: current lane is the lowest still-pending enable.
  always_comb begin
    cur_lane_s   = lowest_lane(pend_r);
    lane_bit_s   = {{(HBYTES-1){1'b0}}, 1'b1} << cur_lane_s;
    pend_clr_s   = pend_r & ~lane_bit_s;
    next_lane_s  = lowest_lane(pend_clr_s);
    first_lane_s = lowest_lane(h_byte_en);
  end

  // Next-state logic and the combinational issue qualification.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (h_req) begin
          if (h_byte_en == {HBYTES{1'b0}}) state_next_s = DONE;
          else                             state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (!m_full) begin
          issue_s = 1'b1;
          if (!wr_r)                            state_next_s = WAITRD;
          else if (pend_clr_s == {HBYTES{1'b0}}) state_next_s = DONE;
          else                                  state_next_s = ISSUE;
        end else begin
          state_next_s = ISSUE;
        end
      end
      WAITRD: begin
        if (m_rvalid) begin
          if (pend_r == {HBYTES{1'b0}}) state_next_s = DONE;
          else                          state_next_s = ISSUE;
        end else begin
          state_next_s = WAITRD;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge t_mem_clk) begin
    if (h_reset) state_r <= IDLE;
    else         state_r <= state_next_s;
  end

  // Request latch, per-lane output preload and read-data assembly.
  always_ff @(posedge t_mem_clk) begin
    if (h_reset) begin
      wr_r      <= 1'b0;
      addr_r    <= {AW{1'b0}};
      wdata_r   <= {(8*HBYTES){1'b0}};
      mode_r    <= 2'b00;
      pend_r    <= {HBYTES{1'b0}};
      lane_r    <= {LW{1'b0}};
      m_wr_r    <= 1'b0;
      m_addr_r  <= {AW{1'b0}};
      m_plane_r <= 4'b0000;
      m_wdata_r <= 8'h00;
      h_rdata_r <= {(8*HBYTES){1'b0}};
      h_done_r  <= 1'b0;
      g_busy_r  <= 1'b0;
    end else begin
      if (state_r == IDLE && h_req) begin
        wr_r      <= h_wr;
        addr_r    <= h_addr;
        wdata_r   <= h_wdata;
        mode_r    <= g_mode;
        pend_r    <= h_byte_en;
        m_wr_r    <= h_wr;
        m_addr_r  <= lane_addr(h_addr, first_lane_s, g_mode);
        m_plane_r <= lane_plane(h_addr, first_lane_s, g_mode);
        m_wdata_r <= lane_byte(h_wdata, first_lane_s);
        if (!h_wr) h_rdata_r <= {(8*HBYTES){1'b0}};
      end else if (issue_s) begin
        // Outputs are preloaded for the following lane so they are ready
        // on the very cycle that lane is issued.
        lane_r <= cur_lane_s;
        pend_r <= pend_clr_s;
        if (pend_clr_s != {HBYTES{1'b0}}) begin
          m_addr_r  <= lane_addr(addr_r, next_lane_s, mode_r);
          m_plane_r <= lane_plane(addr_r, next_lane_s, mode_r);
          m_wdata_r <= lane_byte(wdata_r, next_lane_s);
        end
      end else if (state_r == WAITRD && m_rvalid) begin
        h_rdata_r[{lane_r, 3'b000} +: 8] <= m_rdata;
      end
      h_done_r <= (state_next_s == DONE);
      g_busy_r <= (state_next_s != IDLE);
    end
  end

  assign m_req   = issue_s && !h_reset;
  assign m_wr    = m_wr_r;
  assign m_addr  = m_addr_r;
  assign m_plane = m_plane_r;
  assign m_wdata = m_wdata_r;
  assign h_done  = h_done_r;
  assign h_rdata = h_rdata_r;
  assign g_busy  = g_busy_r;

endmodule

// File: tb/tb_gr_cpu_cycle_seq.sv
// Directed self-checking bench for gr_cpu_cycle_seq (HBYTES=4, AW=23).
module tb_gr_cpu_cycle_seq;

  logic        t_mem_clk = 1'b0;
  logic        h_reset   = 1'b1;
  logic        h_req     = 1'b0;
  logic        h_wr      = 1'b0;
  logic [22:0] h_addr    = 23'h0;
  logic [3:0]  h_byte_en = 4'h0;
  logic [31:0] h_wdata   = 32'h0;
  logic [1:0]  g_mode    = 2'b00;
  logic        m_full    = 1'b0;
  logic        m_rvalid  = 1'b0;
  logic [7:0]  m_rdata   = 8'h00;
  logic        m_req;
  logic        m_wr;
  logic [22:0] m_addr;
  logic [3:0]  m_plane;
  logic [7:0]  m_wdata;
  logic        h_done;
  logic [31:0] h_rdata;
  logic        g_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-transaction record of issued memory cycles.
  int          n_req;
  int          req_cyc   [16];
  logic [22:0] req_addr  [16];
  logic [3:0]  req_plane [16];
  logic [7:0]  req_wdata [16];
  logic        req_wr    [16];
  int          done_cnt;
  int          done_cyc;
  int          end_cyc;
  logic        finished;
  logic [7:0]  rd_bytes  [4];

  gr_cpu_cycle_seq #(.HBYTES(4), .AW(23)) dut (
    .t_mem_clk (t_mem_clk),
    .h_reset   (h_reset),
    .h_req     (h_req),
    .h_wr      (h_wr),
    .h_addr    (h_addr),
    .h_byte_en (h_byte_en),
    .h_wdata   (h_wdata),
    .g_mode    (g_mode),
    .m_full    (m_full),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_plane   (m_plane),
    .m_wdata   (m_wdata),
    .h_done    (h_done),
    .h_rdata   (h_rdata),
    .g_busy    (g_busy)
  );

  always #5 t_mem_clk = ~t_mem_clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one host access; cycle 0 is the h_req cycle. Read data returns two
  // cycles after each read m_req. Inputs change 1ns after the edge, outputs
  // are sampled 2ns after the edge.
  task automatic run_txn(input logic wr, input logic [22:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [1:0] mode,
                         input int stall_at, input int stall_len, input int abort_at,
                         input logic hold_req, input logic spur_rv);
    int due;
    int rd_idx;
    n_req = 0; done_cnt = 0; done_cyc = -1; end_cyc = -1; finished = 1'b0;
    due = -1; rd_idx = 0;
    @(posedge t_mem_clk); #1;
    h_req = 1'b1; h_wr = wr; h_addr = addr; h_byte_en = be; h_wdata = wd; g_mode = mode;
    m_full = 1'b0; m_rvalid = 1'b0;
    @(posedge t_mem_clk); #1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      h_req    = hold_req;
      m_full   = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      m_rvalid = spur_rv || (cyc == due);
      m_rdata  = (cyc == due) ? rd_bytes[rd_idx] : 8'hFF;
      h_reset  = (cyc == abort_at);
      #1;
      if (m_req) begin
        req_cyc[n_req]   = cyc;
        req_addr[n_req]  = m_addr;
        req_plane[n_req] = m_plane;
        req_wdata[n_req] = m_wdata;
        req_wr[n_req]    = m_wr;
        n_req++;
        if (!wr) due = cyc + 2;
      end
      if (cyc == due) rd_idx++;
      if (h_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      @(posedge t_mem_clk); #1;
      if (!g_busy) begin
        finished = 1'b1;
        end_cyc  = cyc;
        break;
      end
    end
    h_req = 1'b0; h_reset = 1'b0; m_full = 1'b0; m_rvalid = 1'b0;
    check_val("txn_terminates", {63'd0, finished}, 64'd1);
  endtask

  initial begin
    // Reset state
    h_reset = 1'b1;
    repeat (2) @(posedge t_mem_clk);
    #2;
    check_val("rst_g_busy",  {63'd0, g_busy}, 64'd0);
    check_val("rst_h_done",  {63'd0, h_done}, 64'd0);
    check_val("rst_m_req",   {63'd0, m_req},  64'd0);
    check_val("rst_h_rdata", {32'd0, h_rdata}, 64'd0);
    check_val("rst_m_addr",  {41'd0, m_addr}, 64'd0);
    check_val("rst_m_plane", {60'd0, m_plane}, 64'd0);
    check_val("rst_m_wdata", {56'd0, m_wdata}, 64'd0);
    check_val("rst_m_wr",    {63'd0, m_wr},   64'd0);
    h_reset = 1'b0;

    // Planar write, all four lanes
    run_txn(1'b1, 23'h000100, 4'b1111, 32'hDDCCBBAA, 2'b00, 99, 0, 99, 1'b0, 1'b0);
    check_val("pw_nreq", n_req, 4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = 32'hDDCCBBAA;
      check_val($sformatf("pw_cyc%0d", i),   req_cyc[i], i + 1);
      check_val($sformatf("pw_addr%0d", i),  {41'd0, req_addr[i]}, 64'h100 + i);
      check_val($sformatf("pw_plane%0d", i), {60'd0, req_plane[i]}, 64'hF);
      check_val($sformatf("pw_byte%0d", i),  {56'd0, req_wdata[i]}, {56'd0, d[8*i +: 8]});
      check_val($sformatf("pw_wr%0d", i),    {63'd0, req_wr[i]}, 64'd1);
    end
    check_val("pw_done_cyc", done_cyc, 5);
    check_val("pw_done_cnt", done_cnt, 1);

    // Chain4 write with address wrap; h_req held high throughout (no queuing)
    run_txn(1'b1, 23'h7FFFFE, 4'b0101, 32'h44332211, 2'b10, 99, 0, 99, 1'b1, 1'b0);
    check_val("c4_nreq",   n_req, 2);
    check_val("c4_addr0",  {41'd0, req_addr[0]},  64'h7FFFFC);
    check_val("c4_plane0", {60'd0, req_plane[0]}, 64'h4);
    check_val("c4_byte0",  {56'd0, req_wdata[0]}, 64'h11);
    check_val("c4_addr1",  {41'd0, req_addr[1]},  64'h0);
    check_val("c4_plane1", {60'd0, req_plane[1]}, 64'h1);
    check_val("c4_byte1",  {56'd0, req_wdata[1]}, 64'h33);
    check_val("c4_done_cyc", done_cyc, 3);
    check_val("c4_done_cnt", done_cnt, 1);

    // Odd/even read, data returned two cycles after each m_req
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22;
    run_txn(1'b0, 23'h000201, 4'b0011, 32'h0, 2'b01, 99, 0, 99, 1'b0, 1'b0);
    check_val("oe_nreq",   n_req, 2);
    check_val("oe_cyc0",   req_cyc[0], 1);
    check_val("oe_cyc1",   req_cyc[1], 4);
    check_val("oe_addr0",  {41'd0, req_addr[0]},  64'h200);
    check_val("oe_plane0", {60'd0, req_plane[0]}, 64'hA);
    check_val("oe_addr1",  {41'd0, req_addr[1]},  64'h202);
    check_val("oe_plane1", {60'd0, req_plane[1]}, 64'h5);
    check_val("oe_wr0",    {63'd0, req_wr[0]}, 64'd0);
    check_val("oe_rdata",  {32'd0, h_rdata}, 64'h00002211);
    check_val("oe_done_cnt", done_cnt, 1);
    check_val("oe_done_cyc", done_cyc, 7);

    // FIFO full for 3 cycles exactly when lane 1 would issue
    run_txn(1'b1, 23'h000300, 4'b1111, 32'h87654321, 2'b00, 2, 3, 99, 1'b0, 1'b0);
    check_val("st_nreq", n_req, 4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = 32'h87654321;
      check_val($sformatf("st_cyc%0d", i),  req_cyc[i], (i == 0) ? 1 : i + 4);
      check_val($sformatf("st_addr%0d", i), {41'd0, req_addr[i]}, 64'h300 + i);
      check_val($sformatf("st_byte%0d", i), {56'd0, req_wdata[i]}, {56'd0, d[8*i +: 8]});
    end
    check_val("st_done_cyc", done_cyc, 8);

    // No byte enables: done one cycle after acceptance
    run_txn(1'b1, 23'h000500, 4'b0000, 32'h12345678, 2'b00, 99, 0, 99, 1'b0, 1'b0);
    check_val("be0_nreq",     n_req, 0);
    check_val("be0_done_cyc", done_cyc, 1);
    check_val("be0_done_cnt", done_cnt, 1);

    // Reset while waiting for read data
    rd_bytes[0] = 8'h99;
    run_txn(1'b0, 23'h000400, 4'b0001, 32'h0, 2'b00, 99, 0, 2, 1'b0, 1'b0);
    check_val("ab_nreq",     n_req, 1);
    check_val("ab_end_cyc",  end_cyc, 2);
    check_val("ab_done_cnt", done_cnt, 0);
    check_val("ab_rdata",    {32'd0, h_rdata}, 64'h0);

    // A fresh read is accepted normally after the abort
    rd_bytes[0] = 8'h5A;
    run_txn(1'b0, 23'h000010, 4'b0010, 32'h0, 2'b00, 99, 0, 99, 1'b0, 1'b0);
    check_val("rr_nreq",     n_req, 1);
    check_val("rr_addr0",    {41'd0, req_addr[0]}, 64'h11);
    check_val("rr_rdata",    {32'd0, h_rdata}, 64'h00005A00);
    check_val("rr_done_cyc", done_cyc, 4);

    // Sparse write in mode 11 with stray m_rvalid; read data must hold
    run_txn(1'b1, 23'h000020, 4'b1010, 32'hA1B2C3D4, 2'b11, 99, 0, 99, 1'b0, 1'b1);
    check_val("sp_nreq",   n_req, 2);
    check_val("sp_cyc1",   req_cyc[1], 2);
    check_val("sp_addr0",  {41'd0, req_addr[0]},  64'h21);
    check_val("sp_byte0",  {56'd0, req_wdata[0]}, 64'hC3);
    check_val("sp_addr1",  {41'd0, req_addr[1]},  64'h23);
    check_val("sp_byte1",  {56'd0, req_wdata[1]}, 64'hA1);
    check_val("sp_plane1", {60'd0, req_plane[1]}, 64'hF);
    check_val("sp_rdata_hold", {32'd0, h_rdata}, 64'h00005A00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
